ysyx_23060240_mem_arbiter: RTL and testbench

Two-port memory arbiter and transaction sequencer between the core's instruction fetch unit (IFU) and load/store unit (LSU) and the single shared data-memory port. It accepts one request at a time, grants round-robin on contention, drives the downstream port with a valid/ready request and waits for its response. It returns read data or write acknowledge to the owning requester and aborts hung transactions with a timeout error.

---
 rtl/ysyx_23060240_mem_arbiter_if.sv | 38 +++
 rtl/ysyx_23060240_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ysyx_23060240_mem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060240_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060240_mem_arbiter_if
// Request/response bundle shared by the IFU, LSU and downstream memory port.
//   req_valid/req_ready : request handshake (requester -> server)
//   wen, addr, wdata,
//   wmask               : request fields, sampled on acceptance
//   resp_valid          : one-cycle completion pulse (no back-pressure)
//   rdata               : read data accompanying resp_valid
// Modports:
//   master   : the side that issues requests
//   slave    : the side that serves requests
//   slave_rd : read-only server view (instruction fetch never writes)
// ----------------------------------------------------------------------------
interface ysyx_23060240_mem_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [7:0]  wmask;
  logic        resp_valid;
  logic [31:0] rdata;

  modport master (
    output req_valid, wen, addr, wdata, wmask,
    input  req_ready, resp_valid, rdata
  );

  modport slave (
    input  req_valid, wen, addr, wdata, wmask,
    output req_ready, resp_valid, rdata
  );

  modport slave_rd (
    input  req_valid, addr,
    output req_ready, resp_valid, rdata
  );
endinterface

// File: rtl/ysyx_23060240_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_23060240_mem_arbiter
// Two-port arbiter/sequencer: IFU and LSU share one downstream memory port.
// One transaction in flight at a time, round-robin grant on contention,
// timeout abort with a bus_err pulse.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   ifu      : IFU read port   (slave_rd view)
//   lsu      : LSU read/write port (slave view)
//   mem      : downstream memory port (master view)
//   bus_err  : one-cycle pulse when a transaction is aborted by timeout
// Parameter:
//   TIMEOUT_CYCLES : cycles allowed in ISSUE+WAIT before abort (1..255)
// ----------------------------------------------------------------------------
module ysyx_23060240_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  ysyx_23060240_mem_arbiter_if.slave_rd ifu,
  ysyx_23060240_mem_arbiter_if.slave    lsu,
  ysyx_23060240_mem_arbiter_if.master   mem,
  output logic bus_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  // Counter holds (cycles spent busy - 1); abort on the cycle it hits this.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        owner_q;        // 0 = IFU, 1 = LSU
  logic        last_grant_q;   // 0 = IFU, 1 = LSU
  logic [7:0]  cnt_q;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  wmask_q;
  logic        ifu_resp_q, lsu_resp_q;
  logic [31:0] ifu_rdata_q, lsu_rdata_q;
  logic        bus_err_q;

  logic grant_ifu, grant_lsu, accept, busy, done, abort;

  // Grant depends only on request valids and state, never on mem inputs.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      grant_lsu = lsu.req_valid && (!ifu.req_valid || !last_grant_q);
      grant_ifu = ifu.req_valid && !grant_lsu;
    end
  end

  assign accept = grant_ifu || grant_lsu;
  assign busy   = (state_q == S_ISSUE) || (state_q == S_WAIT);
  // A response in ISSUE only counts when the request is accepted alongside it.
  assign done   = ((state_q == S_ISSUE) && mem.req_ready && mem.resp_valid) ||
                  ((state_q == S_WAIT) && mem.resp_valid);
  // Completion takes priority over a coincident timeout.
  assign abort  = busy && !done && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: begin
        if (done || abort)      state_d = S_IDLE;
        else if (mem.req_ready) state_d = S_WAIT;
      end
      S_WAIT:  if (done || abort) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ifu.req_ready  = grant_ifu;
    lsu.req_ready  = grant_lsu;
    mem.req_valid  = (state_q == S_ISSUE);
    mem.wen        = wen_q;
    mem.addr       = addr_q;
    mem.wdata      = wdata_q;
    mem.wmask      = wmask_q;
    ifu.resp_valid = ifu_resp_q;
    ifu.rdata      = ifu_rdata_q;
    lsu.resp_valid = lsu_resp_q;
    lsu.rdata      = lsu_rdata_q;
    bus_err        = bus_err_q;
  end

  // Request latch, timeout counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      cnt_q        <= 8'd0;
      wen_q        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wmask_q      <= 8'd0;
      ifu_resp_q   <= 1'b0;
      lsu_resp_q   <= 1'b0;
      ifu_rdata_q  <= 32'd0;
      lsu_rdata_q  <= 32'd0;
      bus_err_q    <= 1'b0;
    end else begin
      ifu_resp_q <= 1'b0;
      lsu_resp_q <= 1'b0;
      bus_err_q  <= 1'b0;

      if (accept) begin
        owner_q      <= grant_lsu;
        last_grant_q <= grant_lsu;
        cnt_q        <= 8'd0;
        if (grant_lsu) begin
          wen_q   <= lsu.wen;
          addr_q  <= lsu.addr;
          wdata_q <= lsu.wdata;
          wmask_q <= lsu.wmask;
        end else begin
          wen_q   <= 1'b0;
          addr_q  <= ifu.addr;
          wdata_q <= 32'd0;
          wmask_q <= 8'd0;
        end
      end else if (busy) begin
        cnt_q <= cnt_q + 8'd1;
      end

      if (done || abort) begin
        if (owner_q) begin
          lsu_resp_q  <= 1'b1;
          lsu_rdata_q <= (abort || wen_q) ? 32'd0 : mem.rdata;
        end else begin
          ifu_resp_q  <= 1'b1;
          ifu_rdata_q <= (abort || wen_q) ? 32'd0 : mem.rdata;
        end
        bus_err_q <= abort;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060240_mem_arbiter
// Bench for the memory arbiter. Each transaction is described by which
// requesters are valid, the request fields, the downstream ready delay and
// response delay; the expected grant, mem fields, response cycle, data and
// error flag are computed from those numbers directly.
// ----------------------------------------------------------------------------
module tb_ysyx_23060240_mem_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic bus_err;

  always #5 clk = ~clk;

  ysyx_23060240_mem_arbiter_if ifu_if ();
  ysyx_23060240_mem_arbiter_if lsu_if ();
  ysyx_23060240_mem_arbiter_if mem_if ();

  ysyx_23060240_mem_arbiter #(.TIMEOUT_CYCLES(TO)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .ifu     (ifu_if),
    .lsu     (lsu_if),
    .mem     (mem_if),
    .bus_err (bus_err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_txn  = 0;
  bit mdl_last = 1'b0;   // last granted requester: 0 IFU, 1 LSU

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    ifu_if.req_valid = 1'b0; ifu_if.addr = '0; ifu_if.wen = 1'b0;
    ifu_if.wdata = '0; ifu_if.wmask = '0;
    lsu_if.req_valid = 1'b0; lsu_if.addr = '0; lsu_if.wen = 1'b0;
    lsu_if.wdata = '0; lsu_if.wmask = '0;
    mem_if.req_ready = 1'b0; mem_if.resp_valid = 1'b0; mem_if.rdata = '0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ifu_resp"}, ifu_if.resp_valid, 0);
    check_eq({tag, "_lsu_resp"}, lsu_if.resp_valid, 0);
    check_eq({tag, "_bus_err"}, bus_err, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    check_eq({tag, "_ifu_rdata"}, ifu_if.rdata, 0);
    check_eq({tag, "_lsu_rdata"}, lsu_if.rdata, 0);
    check_eq({tag, "_mem_valid"}, mem_if.req_valid, 0);
    check_eq({tag, "_mem_addr"}, mem_if.addr, 0);
    check_eq({tag, "_mem_wdata"}, mem_if.wdata, 0);
    check_eq({tag, "_mem_wmask"}, mem_if.wmask, 0);
    check_eq({tag, "_mem_wen"}, mem_if.wen, 0);
  endtask

  // rdy_d: cycles after entering ISSUE before mem_req_ready (one-cycle pulse)
  // rsp_d: cycles after that acceptance before mem_resp_valid (0 = same cycle)
  task automatic run_txn(input bit iv, input bit lv, input bit lwen,
                         input logic [31:0] iaddr, input logic [31:0] laddr,
                         input logic [31:0] lwdata, input logic [7:0] lwmask,
                         input int rdy_d, input int rsp_d, input logic [31:0] rdata);
    bit          own;
    bit          tmo;
    int          k_acc, k_c, k_end;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [7:0]  e_wmask;
    bit          e_wen;

    if (iv && lv) own = ~mdl_last;
    else          own = lv;
    mdl_last = own;
    e_addr  = own ? laddr  : iaddr;
    e_wen   = own ? lwen   : 1'b0;
    e_wdata = own ? lwdata : 32'd0;
    e_wmask = own ? lwmask : 8'd0;
    k_acc   = rdy_d + 1;
    k_c     = k_acc + rsp_d;
    tmo     = (k_c > TO);
    k_end   = tmo ? TO : k_c;
    e_rdata = (tmo || e_wen) ? 32'd0 : rdata;

    @(negedge clk);
    idle_inputs();
    ifu_if.req_valid = iv; ifu_if.addr = iaddr;
    lsu_if.req_valid = lv; lsu_if.wen = lwen; lsu_if.addr = laddr;
    lsu_if.wdata = lwdata; lsu_if.wmask = lwmask;
    #1;
    check_quiet("pre");
    check_eq("ifu_ready", ifu_if.req_ready, iv && !own);
    check_eq("lsu_ready", lsu_if.req_ready, own);

    for (int k = 1; k <= k_end + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // winner drops its request and scrambles its fields: mem must hold latch
        if (own) begin
          lsu_if.req_valid = 1'b0; lsu_if.addr = $urandom; lsu_if.wdata = $urandom;
          lsu_if.wmask = 8'($urandom); lsu_if.wen = 1'($urandom);
        end else begin
          ifu_if.req_valid = 1'b0; ifu_if.addr = $urandom;
        end
      end
      if (k == k_end + 1) begin
        ifu_if.req_valid = 1'b0;
        lsu_if.req_valid = 1'b0;
      end
      mem_if.req_ready  = (k == k_acc);
      mem_if.resp_valid = (k == k_c);
      mem_if.rdata      = (k == k_c) ? rdata : $urandom;
      #1;
      check_eq("both_ready", ifu_if.req_ready & lsu_if.req_ready, 0);
      if (k <= k_end) begin
        check_eq("busy_ready", ifu_if.req_ready | lsu_if.req_ready, 0);
        check_eq("mem_valid", mem_if.req_valid, k <= k_acc);
        if (k <= k_acc) begin
          check_eq("mem_addr", mem_if.addr, e_addr);
          check_eq("mem_wen", mem_if.wen, e_wen);
          check_eq("mem_wdata", mem_if.wdata, e_wdata);
          check_eq("mem_wmask", mem_if.wmask, e_wmask);
        end
        check_quiet("busy");
      end else begin
        check_eq("mem_valid_done", mem_if.req_valid, 0);
        check_eq("ifu_resp", ifu_if.resp_valid, !own);
        check_eq("lsu_resp", lsu_if.resp_valid, own);
        check_eq("bus_err", bus_err, tmo);
        if (own) check_eq("lsu_rdata", lsu_if.rdata, e_rdata);
        else     check_eq("ifu_rdata", ifu_if.rdata, e_rdata);
      end
    end
    n_txn++;
    $display("txn %0d: owner=%s addr=0x%08h wen=%0d rdy_d=%0d rsp_d=%0d timeout=%0d rdata=0x%08h",
             n_txn, own ? "LSU" : "IFU", e_addr, e_wen, rdy_d, rsp_d, tmo, e_rdata);
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    idle_inputs();
    lsu_if.req_valid = 1'b1; lsu_if.addr = 32'h8000_2000;
    #1;
    check_eq("rst_t_lsu_ready", lsu_if.req_ready, 1);
    @(negedge clk);
    lsu_if.req_valid = 1'b0; mem_if.req_ready = 1'b1;
    @(negedge clk);
    mem_if.req_ready = 1'b0;
    #1;
    check_eq("rst_t_in_wait", mem_if.req_valid, 0);
    @(negedge clk);
    rst = 1'b1; ifu_if.req_valid = 1'b1; lsu_if.req_valid = 1'b1;
    #1;
    check_eq("rst_t_ready_in_rst", ifu_if.req_ready | lsu_if.req_ready, 0);
    @(negedge clk);
    rst = 1'b0; ifu_if.req_valid = 1'b0; lsu_if.req_valid = 1'b0;
    mem_if.resp_valid = 1'b1; mem_if.rdata = 32'h1234_5678;   // late response
    #1;
    check_all_zero("rst_t_after");
    @(negedge clk);
    mem_if.resp_valid = 1'b0;
    #1;
    check_all_zero("rst_t_late");
    mdl_last = 1'b0;
    $display("txn reset-mid-wait: transaction dropped");
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    ifu_if.req_valid = 1'b1; lsu_if.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_eq("rst_ready", ifu_if.req_ready | lsu_if.req_ready, 0);
    end
    @(negedge clk);
    rst = 1'b0; idle_inputs();
    #1;
    check_all_zero("reset");

    // single IFU read and LSU write with held-off ready
    run_txn(1, 0, 0, 32'h8000_0000, 0, 0, 0, 0, 2, 32'h0000_0413);
    run_txn(0, 1, 1, 0, 32'h8000_1004, 32'hDEAD_BEEF, 8'h0F, 3, 1, 32'h5555_AAAA);
    // fresh state for the tie sequence: LSU, IFU, LSU, IFU
    reset_mid_wait();
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 0, 32'h8000_0100 + 32'(4 * i), 32'h8000_3000 + 32'(4 * i),
              0, 0, i % 2, i % 3, $urandom);
    // zero latency, timeout boundaries, never-ready, never-respond
    run_txn(1, 0, 0, 32'h8000_0040, 0, 0, 0, 0, 0, 32'hCAFE_0001);
    run_txn(0, 1, 0, 0, 32'h8000_0800, 0, 0, 3, 4, 32'hCAFE_0002);    // completes on last cycle
    run_txn(1, 0, 0, 32'h8000_0044, 0, 0, 0, 3, 5, 32'hCAFE_0003);    // one cycle late
    run_txn(0, 1, 1, 0, 32'h8000_0808, 32'h0BAD_F00D, 8'hFF, 0, 99, 0);
    run_txn(1, 0, 0, 32'h8000_0048, 0, 0, 0, 99, 0, 32'hCAFE_0004);
    // reset during WAIT, then a tie must go to the LSU
    reset_mid_wait();
    run_txn(1, 1, 0, 32'h8000_0050, 32'h8000_0900, 0, 0, 1, 1, 32'hCAFE_0005);

    for (int i = 0; i < 40; i++) begin
      int  sel;
      int  rd, rs;
      sel = int'($urandom_range(1, 3));
      rd  = int'($urandom_range(0, 5));
      rs  = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 4));
      run_txn(sel[0], sel[1], 1'($urandom), $urandom, $urandom, $urandom,
              8'($urandom), rd, rs, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
